// File: rtl/sar_comp_search_if.sv
// sar_comp_search_if: start request, comparator flags and search results of the SAR controller.
interface sar_comp_search_if #(parameter int WIDTH = 4);
    logic             start;
    logic             L;
    logic             E;
    logic             S;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
    modport master (output start, L, E, S, input guess, busy, done, result, err);
    modport slave  (input start, L, E, S, output guess, busy, done, result, err);
endinterface

// File: rtl/sar_comp_search.sv
// sar_comp_search: MSB-first successive-approximation search of a value seen only through L/E/S comparator flags.
module sar_comp_search #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    sar_comp_search_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, TRIAL, FINISH} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] bit_m;
    logic [WIDTH-1:0] kept;
    logic             onehot;

    assign onehot = (bus.L ^ bus.E ^ bus.S) & ~(bus.L & bus.E & bus.S);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        guess_d  = guess_q;
        result_d = result_q;
        err_d    = err_q;
        bit_m    = '0;
        bit_m[bit_q] = 1'b1;
        kept     = bus.S ? guess_q : guess_q & ~bit_m;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    guess_d = {1'b1, {(WIDTH-1){1'b0}}};
                    bit_d   = IW'(WIDTH-1);
                    err_d   = 1'b0;
                    state_d = TRIAL;
                end
            end
            TRIAL: begin
                if (!onehot || bus.E) begin
                    result_d = guess_q;
                    err_d    = !onehot;
                    state_d  = FINISH;
                end else if (bit_q != '0) begin
                    guess_d = kept | (bit_m >> 1);
                    bit_d   = bit_q - IW'(1);
                end else begin
                    // S on the last bit means the target exceeds every reachable guess
                    guess_d  = kept;
                    result_d = kept;
                    err_d    = bus.S;
                    state_d  = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bit_q    <= IW'(WIDTH-1);
            guess_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = state_q != IDLE;
    assign bus.done   = state_q == FINISH;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule
